// File: rtl/decoder_pkg.sv
// Shared FSM state, mode encodings and the bounded index-to-one-hot helper for scan_decoder.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int ONEHOT_MAX = 64;

    // Callers size-cast the result down to their own bus width.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int n);
        logic [ONEHOT_MAX-1:0] one;
        one = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
        return (idx >= 0 && idx < n) ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter timing how long a scan channel is held; expire flags a zero count while enabled.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select driver: handshaked direct index load or autonomous dwell-timed scan.
// Build option SCAN_DECODER_MASK_EN adds chan_mask: scan skips masked channels, masked loads flag err.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_N   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   Nbit,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_DECODER_MASK_EN
    input  logic [OUT_N-1:0]   chan_mask,
`endif
    output logic [OUT_N-1:0]   Ndecimal,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               wrap,
    output logic               err
);

    state_t           state;
    logic [OUT_N-1:0] mask;
    logic [OUT_N-1:0] rot;
    logic [OUT_N-1:0] load_hot, first_hot, next_hot;
    logic [SEL_W-1:0] next_idx, first_idx;
    logic             next_wrap, load_bad;
    logic             go_idle, go_scan, advance, expire;

`ifdef SCAN_DECODER_MASK_EN
    assign mask = chan_mask;
`else
    assign mask = '1;
`endif

    // Next enabled channel after cur_sel (descending loop so the nearest offset wins).
    always_comb begin
        rot       = '0;
        next_idx  = cur_sel;
        next_wrap = 1'b0;
        first_idx = '0;
        for (int i = OUT_N; i >= 1; i--) begin
            rot = mask >> ((int'(cur_sel) + i) % OUT_N);
            if (rot[0]) begin
                next_idx  = SEL_W'((int'(cur_sel) + i) % OUT_N);
                next_wrap = (int'(cur_sel) + i) >= OUT_N;
            end
        end
        if (mask == '0) begin
            next_wrap = 1'b1;
        end
        for (int i = OUT_N - 1; i >= 0; i--) begin
            rot = mask >> i;
            if (rot[0]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    assign load_hot  = OUT_N'(onehot(int'(Nbit), OUT_N)) & mask;
    assign first_hot = OUT_N'(onehot(int'(first_idx), OUT_N)) & mask;
    assign next_hot  = OUT_N'(onehot(int'(next_idx), OUT_N)) & mask;
    assign load_bad  = (load_hot == '0);

    // stop dominates start; an all-masked scan spins every cycle so wrap keeps pulsing.
    assign go_idle = (state == SCAN) && (stop || mode == MODE_DIRECT);
    assign go_scan = !stop && start && (mode == MODE_SCAN);
    assign advance = (state == SCAN) && !go_idle && !go_scan && (expire || mask == '0);

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clr      (go_idle),
        .load     (go_scan || advance),
        .en       (state == SCAN),
        .load_val (dwell),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            Ndecimal   <= '0;
            cur_sel    <= '0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (go_idle) begin
                state      <= IDLE;
                Ndecimal   <= '0;
                busy       <= 1'b0;
                load_ready <= 1'b1;
            end else if (go_scan) begin
                state      <= SCAN;
                Ndecimal   <= first_hot;
                cur_sel    <= first_idx;
                busy       <= 1'b1;
                load_ready <= 1'b0;
            end else if (advance) begin
                Ndecimal <= next_hot;
                cur_sel  <= next_idx;
                wrap     <= next_wrap;
            end else if (state == IDLE && load_valid) begin
                Ndecimal <= load_hot;
                cur_sel  <= Nbit;
                err      <= load_bad;
            end
        end
    end

endmodule
